branch_redirect_ctrl: RTL and testbench

//  Sequences control-flow redirects for the 3-stage pipeline. Consumes the EX-stage branch

---
 rtl/core_ctrl_pkg.sv | 21 ++
 rtl/sat_counter.sv | 25 ++
 rtl/branch_redirect_ctrl.sv | 91 +++++++++
 tb/tb_branch_redirect_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared control-path types for the 3-stage core: branch kinds and the redirect FSM states.
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_COND = 2'b01,
    BR_JUMP = 2'b10
  } br_type_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    REDIRECT = 2'b01,
    EXC      = 2'b10
  } redir_state_e;

  // 2'b11 is not a legal branch kind and behaves like BR_NONE.
  function automatic logic br_is_taken(input logic [1:0] br_type, input logic take);
    return (br_type == BR_JUMP) || ((br_type == BR_COND) && take);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns EX-stage branch resolutions into a handshaked PC redirect toward fetch, pipeline
// flushes and misaligned-target exceptions, and keeps saturating branch statistics.
module branch_redirect_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CNT_W      = 32,
  parameter int IALIGN_LSB = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid_i,
  input  logic [1:0]       ex_br_type_i,
  input  logic             ex_take_branch_i,
  input  logic [XLEN-1:0]  ex_target_i,
  input  logic             stall_i,
  output logic             redir_valid_o,
  output logic [XLEN-1:0]  redir_pc_o,
  input  logic             redir_ready_i,
  output logic             flush_o,
  output logic             exc_valid_o,
  output logic [XLEN-1:0]  exc_addr_o,
  output logic [CNT_W-1:0] br_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o,
  output logic [CNT_W-1:0] redir_wait_cnt_o
);

  redir_state_e    state_q, state_d;
  logic [XLEN-1:0] redir_pc_q, exc_addr_q;

  logic resolve, taken, aligned, go_redirect, go_exc, wait_inc;

  // Only RUN considers EX; in REDIRECT/EXC the EX slot is younger and being squashed.
  assign resolve     = ex_valid_i && !stall_i && (state_q == RUN) &&
                       ((ex_br_type_i == BR_COND) || (ex_br_type_i == BR_JUMP));
  assign taken       = resolve && br_is_taken(ex_br_type_i, ex_take_branch_i);
  assign aligned     = (ex_target_i[IALIGN_LSB-1:0] == '0);
  assign go_redirect = taken && aligned;
  assign go_exc      = taken && !aligned;
  assign wait_inc    = (state_q == REDIRECT) && !redir_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (go_redirect) state_d = REDIRECT;
        else if (go_exc) state_d = EXC;
      end
      REDIRECT: if (redir_ready_i) state_d = RUN;
      EXC:      state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    redir_valid_o = (state_q == REDIRECT);
    exc_valid_o   = (state_q == EXC);
    flush_o       = (state_q == REDIRECT) || (state_q == EXC);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redir_pc_q <= '0;
      exc_addr_q <= '0;
    end else begin
      if (go_redirect) redir_pc_q <= ex_target_i;
      if (go_exc)      exc_addr_q <= ex_target_i;
    end
  end

  assign redir_pc_o = redir_pc_q;
  assign exc_addr_o = exc_addr_q;

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(resolve), .cnt_o(br_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(go_redirect), .cnt_o(taken_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_wait_cnt (
    .clk(clk), .rst_n(rst_n), .inc_i(wait_inc), .cnt_o(redir_wait_cnt_o)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed vector table, hand sequences, and random traffic
// against an event-level reference model (wide and 4-bit-counter instances side by side).
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_take, stall, ready;
  logic [1:0]  ex_type;
  logic [31:0] ex_target;

  logic        rv_a, fl_a, ex_a, rv_b, fl_b, ex_b;
  logic [31:0] pc_a, ea_a, pc_b, ea_b;
  logic [31:0] br_a, tk_a, wt_a;
  logic [3:0]  br_b, tk_b, wt_b;

  int total = 0;
  int bad   = 0;

  // Reference model: counters are unbounded and clipped only when compared.
  bit          m_pend, m_exc;
  logic [31:0] m_pc, m_ea;
  longint      m_br, m_taken, m_wait;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.XLEN(32), .CNT_W(32), .IALIGN_LSB(2)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_br_type_i(ex_type),
    .ex_take_branch_i(ex_take), .ex_target_i(ex_target), .stall_i(stall),
    .redir_valid_o(rv_a), .redir_pc_o(pc_a), .redir_ready_i(ready), .flush_o(fl_a),
    .exc_valid_o(ex_a), .exc_addr_o(ea_a), .br_cnt_o(br_a), .taken_cnt_o(tk_a),
    .redir_wait_cnt_o(wt_a)
  );

  branch_redirect_ctrl #(.XLEN(32), .CNT_W(4), .IALIGN_LSB(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid), .ex_br_type_i(ex_type),
    .ex_take_branch_i(ex_take), .ex_target_i(ex_target), .stall_i(stall),
    .redir_valid_o(rv_b), .redir_pc_o(pc_b), .redir_ready_i(ready), .flush_o(fl_b),
    .exc_valid_o(ex_b), .exc_addr_o(ea_b), .br_cnt_o(br_b), .taken_cnt_o(tk_b),
    .redir_wait_cnt_o(wt_b)
  );

  typedef struct {
    logic        v;
    logic [1:0]  ty;
    logic        tk;
    logic [31:0] tgt;
    logic        st;
    logic        rdy;
    logic        e_rv;
    logic        e_fl;
    logic        e_ex;
    logic [31:0] e_pc;
    logic [31:0] e_ea;
    int          e_br;
    int          e_tk;
    int          e_wt;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  function automatic longint clip(input longint v, input int w);
    longint lim;
    lim = (longint'(1) <<< w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_pend = 0; m_exc = 0; m_pc = '0; m_ea = '0;
      m_br = 0; m_taken = 0; m_wait = 0;
    end else if (m_pend) begin
      if (ready) m_pend = 0;
      else       m_wait++;
    end else if (m_exc) begin
      m_exc = 0;
    end else if (ex_valid && !stall && (ex_type == 2'd1 || ex_type == 2'd2)) begin
      m_br++;
      if (ex_type == 2'd2 || ex_take) begin
        if (ex_target % 4 == 0) begin
          m_pend = 1; m_pc = ex_target; m_taken++;
        end else begin
          m_exc = 1; m_ea = ex_target;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("m_rv",    64'(rv_a), 64'(m_pend));
    chk("m_fl",    64'(fl_a), 64'(m_pend || m_exc));
    chk("m_ex",    64'(ex_a), 64'(m_exc));
    chk("m_pc",    64'(pc_a), 64'(m_pc));
    chk("m_ea",    64'(ea_a), 64'(m_ea));
    chk("m_br",    64'(br_a), 64'(clip(m_br, 32)));
    chk("m_tk",    64'(tk_a), 64'(clip(m_taken, 32)));
    chk("m_wt",    64'(wt_a), 64'(clip(m_wait, 32)));
    chk("m4_flags", {61'd0, rv_b, fl_b, ex_b}, {61'd0, m_pend, m_pend || m_exc, m_exc});
    chk("m4_br",   64'(br_b), 64'(clip(m_br, 4)));
    chk("m4_tk",   64'(tk_b), 64'(clip(m_taken, 4)));
    chk("m4_wt",   64'(wt_b), 64'(clip(m_wait, 4)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic set_idle();
    ex_valid = 1'b0; ex_type = 2'd0; ex_take = 1'b0; ex_target = '0;
    stall = 1'b0; ready = 1'b1;
  endtask

  task automatic branch(input logic [1:0] ty, input logic tk, input logic [31:0] tgt);
    ex_valid = 1'b1; ex_type = ty; ex_take = tk; ex_target = tgt;
  endtask

  initial begin
    // BEQ taken, not taken, misaligned jump, JAL under 3 cycles of fetch backpressure.
    tbl[0]  = '{1'b1, 2'd1, 1'b1, 32'h100,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100,  32'h0,   1, 1, 0};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100,  32'h0,   1, 1, 0};
    tbl[2]  = '{1'b1, 2'd1, 1'b0, 32'h200,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100,  32'h0,   2, 1, 0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100,  32'h0,   2, 1, 0};
    tbl[4]  = '{1'b1, 2'd2, 1'b0, 32'h102,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100,  32'h102, 3, 1, 0};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100,  32'h102, 3, 1, 0};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 32'h2000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h102, 4, 2, 0};
    tbl[7]  = '{1'b0, 2'd0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h102, 4, 2, 1};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h102, 4, 2, 2};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h102, 4, 2, 3};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2000, 32'h102, 4, 2, 3};

    set_idle();
    rst_n = 1'b0;
    step();
    step();
    chk("rst_outs", {61'd0, rv_a, fl_a, ex_a}, 64'd0);
    chk("rst_pc", 64'(pc_a), 64'd0);
    chk("rst_ea", 64'(ea_a), 64'd0);
    chk("rst_cnts", {br_a, tk_a}, 64'd0);
    $display("reset: rv=%0b fl=%0b ex=%0b br=%0d", rv_a, fl_a, ex_a, br_a);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      ex_valid = tbl[i].v; ex_type = tbl[i].ty; ex_take = tbl[i].tk;
      ex_target = tbl[i].tgt; stall = tbl[i].st; ready = tbl[i].rdy;
      step();
      chk($sformatf("v%0d_flags", i), {61'd0, rv_a, fl_a, ex_a},
          {61'd0, tbl[i].e_rv, tbl[i].e_fl, tbl[i].e_ex});
      chk($sformatf("v%0d_pc", i), 64'(pc_a), 64'(tbl[i].e_pc));
      chk($sformatf("v%0d_ea", i), 64'(ea_a), 64'(tbl[i].e_ea));
      chk($sformatf("v%0d_cnt", i), {br_a, tk_a}, {32'(tbl[i].e_br), 32'(tbl[i].e_tk)});
      chk($sformatf("v%0d_wait", i), 64'(wt_a), 64'(tbl[i].e_wt));
      $display("vec %0d: rv=%0b fl=%0b ex=%0b pc=%0h br=%0d tk=%0d wt=%0d",
               i, rv_a, fl_a, ex_a, pc_a, br_a, tk_a, wt_a);
    end

    // Stall holds a taken jump for 2 cycles, then a second jump arrives during REDIRECT.
    set_idle();
    branch(2'd2, 1'b0, 32'h300);
    stall = 1'b1;
    step();
    chk("s5_stall1_rv", 64'(rv_a), 64'd0);
    step();
    chk("s5_stall2_br", 64'(br_a), 64'd4);
    stall = 1'b0;
    step();
    chk("s5_go_rv", 64'(rv_a), 64'd1);
    chk("s5_go_pc", 64'(pc_a), 64'h300);
    branch(2'd2, 1'b0, 32'h400);
    ready = 1'b0;
    step();
    chk("s5_hold_pc", 64'(pc_a), 64'h300);
    chk("s5_hold_br", 64'(br_a), 64'd5);
    ready = 1'b1;
    step();
    chk("s5_leave_rv", 64'(rv_a), 64'd0);
    chk("s5_leave_br", 64'(br_a), 64'd5);
    $display("seq stall/squash: pc=%0h br=%0d tk=%0d", pc_a, br_a, tk_a);

    // Reset in the middle of a stalled redirect abandons it.
    set_idle();
    branch(2'd2, 1'b0, 32'h500);
    ready = 1'b0;
    step();
    chk("s6_pre_rv", 64'(rv_a), 64'd1);
    set_idle();
    ready = 1'b0;
    rst_n = 1'b0;
    step();
    chk("s6_rst_flags", {61'd0, rv_a, fl_a, ex_a}, 64'd0);
    chk("s6_rst_pc", 64'(pc_a), 64'd0);
    chk("s6_rst_cnt", {br_a, tk_a}, 64'd0);
    rst_n = 1'b1;
    ready = 1'b1;
    step();
    chk("s6_after_rv", 64'(rv_a), 64'd0);
    $display("seq reset-in-redirect: rv=%0b pc=%0h br=%0d", rv_a, pc_a, br_a);

    for (int i = 0; i < 20; i++) begin
      set_idle();
      branch(2'd2, 1'b0, 32'(i * 64 + 64));
      step();
      set_idle();
      step();
    end
    chk("sat4_br", 64'(br_b), 64'd15);
    chk("sat4_tk", 64'(tk_b), 64'd15);
    chk("sat32_br", 64'(br_a), 64'd20);
    chk("sat32_tk", 64'(tk_a), 64'd20);
    $display("seq saturation: br4=%0d tk4=%0d br32=%0d tk32=%0d", br_b, tk_b, br_a, tk_a);

    for (int i = 0; i < 600; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      ex_valid  = ($urandom_range(0, 3) != 0);
      ex_type   = 2'($urandom_range(0, 3));
      ex_take   = 1'($urandom_range(0, 1));
      ex_target = $urandom;
      if ($urandom_range(0, 7) != 0) ex_target[1:0] = 2'b00;
      stall     = ($urandom_range(0, 4) == 0);
      ready     = ($urandom_range(0, 2) != 0);
      step();
    end
    $display("random: br=%0d tk=%0d wt=%0d", br_a, tk_a, wt_a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
